// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - button-driven 16-bit accumulator calculator with debounced execute/clear
// Optional signed-overflow flag built only when CALC_OVF_EN is defined.
module calc_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btnl,
  input  logic              btnc,
  input  logic              btnr,
  input  logic              btnd,
  input  logic              btnac,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] led,
  output logic [3:0]        alu_op_q,
  output logic              busy,
  output logic              op_err,
  output logic              ovf
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [4:0]        sync1, sync2;
  logic              l_s, c_s, r_s, d_s, ac_s;
  logic              d_deb, d_deb_q, ac_deb, ac_deb_q;
  logic [DEB_W-1:0]  d_cnt, ac_cnt;
  logic              exec_pulse, clr_pulse;
  logic [1:0]        state;
  logic [DATA_W-1:0] opb;
  logic [3:0]        op_enc;
  logic [DATA_W-1:0] result;
  logic              op_valid;
  logic [DATA_W-1:0] sum, diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btnl, btnc, btnr, btnd, btnac};
      sync2 <= sync1;
    end
  end

  assign {l_s, c_s, r_s, d_s, ac_s} = sync2;

  // The counter only advances while the input disagrees with the debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_deb <= 1'b0;
      d_cnt <= '0;
    end else if (d_s == d_deb) begin
      d_cnt <= '0;
    end else if (d_cnt == DEB_LAST) begin
      d_deb <= d_s;
      d_cnt <= '0;
    end else begin
      d_cnt <= d_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ac_deb <= 1'b0;
      ac_cnt <= '0;
    end else if (ac_s == ac_deb) begin
      ac_cnt <= '0;
    end else if (ac_cnt == DEB_LAST) begin
      ac_deb <= ac_s;
      ac_cnt <= '0;
    end else begin
      ac_cnt <= ac_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_deb_q  <= 1'b0;
      ac_deb_q <= 1'b0;
    end else begin
      d_deb_q  <= d_deb;
      ac_deb_q <= ac_deb;
    end
  end

  assign exec_pulse = d_deb & ~d_deb_q;
  assign clr_pulse  = ac_deb & ~ac_deb_q;

  always_comb begin
    op_enc = 4'b0000;
    case ({l_s, c_s, r_s})
      3'b000: op_enc = 4'b0000;
      3'b001: op_enc = 4'b0001;
      3'b010: op_enc = 4'b0010;
      3'b011: op_enc = 4'b0110;
      3'b100: op_enc = 4'b0100;
      3'b101: op_enc = 4'b1001;
      3'b110: op_enc = 4'b1010;
      default: op_enc = 4'b0101;
    endcase
  end

  assign sum  = led + opb;
  assign diff = led - opb;

  always_comb begin
    result   = led;
    op_valid = 1'b1;
    case (alu_op_q)
      4'b0000: result = led & opb;
      4'b0001: result = led | opb;
      4'b0010: result = sum;
      4'b0110: result = diff;
      4'b0100: result = led ^ opb;
      4'b1001: result = led << opb[3:0];
      4'b1010: result = $signed(led) >>> opb[3:0];
      4'b0101: result = {{(DATA_W-1){1'b0}}, ($signed(led) < $signed(opb))};
      default: begin
        result   = led;
        op_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      alu_op_q <= 4'b0000;
      opb      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (exec_pulse) begin
            alu_op_q <= op_enc;
            opb      <= sw;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC:     state <= ST_WAIT_REL;
        ST_WAIT_REL: if (!d_deb) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Clear has priority over a coinciding EXEC write.
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= '0;
      op_err <= 1'b0;
    end else if (clr_pulse) begin
      led    <= '0;
      op_err <= 1'b0;
    end else if (state == ST_EXEC) begin
      led    <= result;
      op_err <= ~op_valid;
    end
  end

`ifdef CALC_OVF_EN
  logic add_ovf, sub_ovf;
  assign add_ovf = (led[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != led[DATA_W-1]);
  assign sub_ovf = (led[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != led[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (rst || clr_pulse) begin
      ovf <= 1'b0;
    end else if (state == ST_EXEC) begin
      if ((alu_op_q == 4'b0010 && add_ovf) || (alu_op_q == 4'b0110 && sub_ovf))
        ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state == ST_EXEC) || (state == ST_WAIT_REL);

endmodule
